// File: rtl/wrpt_full_level.sv
// -----------------------------------------------------------------------------
// wrpt_full_level
//
// Write-side pointer and flag generator for an asynchronous FIFO. Keeps the
// binary and Gray write pointers, drives the RAM write address and enable, and
// produces registered full, fill-level, programmable almost-full and sticky
// overflow indications. Everything lives in the write clock domain and uses a
// Gray read pointer that has already been synchronised into this domain.
//
// Parameters
//   address_size : RAM address width, FIFO depth = 2**address_size (>= 2)
//
// Ports
//   write_clk_i                   : write-domain clock
//   write_reset_i                 : synchronous, active-high reset
//   read_to_write_pointer_i       : synchronised Gray read pointer
//   write_increment_i             : write request
//   write_almost_full_threshold_i : almost-full level threshold (unsigned)
//   write_overflow_clear_i        : clears the sticky overflow flag
//   write_enable_o                : write accepted this cycle (RAM write enable)
//   write_address_o               : RAM write address
//   write_pointer_o               : Gray write pointer, to read-domain sync
//   write_full_o                  : FIFO full (registered)
//   write_almost_full_o           : level >= threshold (registered)
//   write_level_o                 : words in FIFO as seen from write domain
//   write_overflow_o              : sticky, write attempted while full
// -----------------------------------------------------------------------------
module wrpt_full_level #(
    parameter int address_size = 3
) (
    input  logic                    write_clk_i,
    input  logic                    write_reset_i,
    input  logic [address_size:0]   read_to_write_pointer_i,
    input  logic                    write_increment_i,
    input  logic [address_size:0]   write_almost_full_threshold_i,
    input  logic                    write_overflow_clear_i,
    output logic                    write_enable_o,
    output logic [address_size-1:0] write_address_o,
    output logic [address_size:0]   write_pointer_o,
    output logic                    write_full_o,
    output logic                    write_almost_full_o,
    output logic [address_size:0]   write_level_o,
    output logic                    write_overflow_o
);

    localparam int PW = address_size + 1;

    // Level value meaning "every RAM slot holds unread data".
    localparam logic [PW-1:0] DEPTH = {1'b1, {address_size{1'b0}}};

    // Binary to reflected Gray code.
    function automatic logic [PW-1:0] bin_to_gray(input logic [PW-1:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Gray to binary: MSB copied, each lower bit folds in all higher Gray bits.
    function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] gray);
        logic [PW-1:0] bin;
        bin[PW-1] = gray[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wgray;
    logic          r_full;
    logic          r_almost_full;
    logic [PW-1:0] r_level;
    logic          r_overflow;

    logic          w_write_enable;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_level_next;
    logic [PW-1:0] w_full_pattern;
    logic          w_full_next;
    logic          w_full_by_level;
    logic          w_almost_full_next;
    logic          w_overflow_set;

    // Next-state computation for pointers, level and flags.
    always_comb begin
        w_write_enable     = 1'b0;
        w_wbin_next        = r_wbin;
        w_wgray_next       = r_wgray;
        w_rbin             = {PW{1'b0}};
        w_level_next       = {PW{1'b0}};
        w_full_pattern     = {PW{1'b0}};
        w_full_next        = 1'b0;
        w_full_by_level    = 1'b0;
        w_almost_full_next = 1'b0;
        w_overflow_set     = 1'b0;

        // A request while full is dropped and flagged instead of accepted.
        w_write_enable = write_increment_i & ~r_full;
        w_overflow_set = write_increment_i & r_full;

        w_wbin_next  = r_wbin + {{address_size{1'b0}}, w_write_enable};
        w_wgray_next = bin_to_gray(w_wbin_next);

        w_rbin       = gray_to_bin(read_to_write_pointer_i);
        w_level_next = w_wbin_next - w_rbin;

        // In Gray code, "one lap ahead" means the two MSBs differ and the rest match.
        w_full_pattern = {~read_to_write_pointer_i[PW-1:PW-2],
                          read_to_write_pointer_i[PW-3:0]};
        w_full_next    = (w_wgray_next == w_full_pattern);

        // Independent full derivation, cross-checked against the Gray compare.
        w_full_by_level = (w_level_next == DEPTH);

        w_almost_full_next = (w_level_next >= write_almost_full_threshold_i);
    end

    // State registers with synchronous reset; overflow set wins over clear.
    always_ff @(posedge write_clk_i) begin
        if (write_reset_i) begin
            r_wbin        <= {PW{1'b0}};
            r_wgray       <= {PW{1'b0}};
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_level       <= {PW{1'b0}};
            r_overflow    <= 1'b0;
        end else begin
            r_wbin        <= w_wbin_next;
            r_wgray       <= w_wgray_next;
            r_full        <= w_full_next;
            r_almost_full <= w_almost_full_next;
            r_level       <= w_level_next;
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end else if (write_overflow_clear_i) begin
                r_overflow <= 1'b0;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    assign write_enable_o      = w_write_enable;
    assign write_address_o     = r_wbin[address_size-1:0];
    assign write_pointer_o     = r_wgray;
    assign write_full_o        = r_full;
    assign write_almost_full_o = r_almost_full;
    assign write_level_o       = r_level;
    assign write_overflow_o    = r_overflow;

    wrpt_full_level_checker #(
        .PW (PW)
    ) u_checker (
        .clk_i           (write_clk_i),
        .reset_i         (write_reset_i),
        .full_by_gray_i  (w_full_next),
        .full_by_level_i (w_full_by_level),
        .enable_i        (w_write_enable),
        .gray_q_i        (r_wgray),
        .gray_next_i     (w_wgray_next)
    );

endmodule

// -----------------------------------------------------------------------------
// wrpt_full_level_checker
//
// Property checks for wrpt_full_level: the Gray-compare full and the
// level-based full must agree, and the Gray pointer moves by exactly one bit
// per accepted write and holds otherwise.
//
// Ports
//   clk_i, reset_i     : write clock and synchronous reset
//   full_by_gray_i     : next full from the Gray pointer compare
//   full_by_level_i    : next full from level == depth
//   enable_i           : write accepted this cycle
//   gray_q_i           : current Gray write pointer
//   gray_next_i        : next Gray write pointer
// -----------------------------------------------------------------------------
module wrpt_full_level_checker #(
    parameter int PW = 4
) (
    input logic          clk_i,
    input logic          reset_i,
    input logic          full_by_gray_i,
    input logic          full_by_level_i,
    input logic          enable_i,
    input logic [PW-1:0] gray_q_i,
    input logic [PW-1:0] gray_next_i
);

    a_full_agree : assert property (@(posedge clk_i) disable iff (reset_i)
        full_by_gray_i == full_by_level_i);

    a_gray_one_bit : assert property (@(posedge clk_i) disable iff (reset_i)
        enable_i |-> $onehot(gray_q_i ^ gray_next_i));

    a_gray_hold : assert property (@(posedge clk_i) disable iff (reset_i)
        !enable_i |-> (gray_q_i == gray_next_i));

endmodule

// File: tb/tb_wrpt_full_level.sv
// -----------------------------------------------------------------------------
// tb_wrpt_full_level
//
// Self-checking bench for wrpt_full_level (address_size = 3). Each cycle's
// stimulus pushes the expected post-edge outputs onto a queue; the test task
// pops and compares them one time unit after the clock edge. Spot checks
// against hand-written constants cover the Gray sequence and flag boundaries.
// -----------------------------------------------------------------------------
module tb_wrpt_full_level;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rptr;
    logic       inc;
    logic [3:0] thr;
    logic       clr;
    logic       write_enable_o;
    logic [2:0] write_address_o;
    logic [3:0] write_pointer_o;
    logic       write_full_o;
    logic       write_almost_full_o;
    logic [3:0] write_level_o;
    logic       write_overflow_o;

    typedef struct packed {
        logic       en;
        logic [3:0] ptr;
        logic [2:0] addr;
        logic [3:0] lvl;
        logic       full;
        logic       af;
        logic       ovf;
    } exp_t;

    exp_t q[$];

    logic [3:0] m_bin;
    logic       m_full;
    logic       m_ovf;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] gtab [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                             4'b0111, 4'b0101, 4'b0100, 4'b1100};

    wrpt_full_level #(.address_size(3)) dut (
        .write_clk_i                   (clk),
        .write_reset_i                 (rst),
        .read_to_write_pointer_i       (rptr),
        .write_increment_i             (inc),
        .write_almost_full_threshold_i (thr),
        .write_overflow_clear_i        (clr),
        .write_enable_o                (write_enable_o),
        .write_address_o               (write_address_o),
        .write_pointer_o               (write_pointer_o),
        .write_full_o                  (write_full_o),
        .write_almost_full_o           (write_almost_full_o),
        .write_level_o                 (write_level_o),
        .write_overflow_o              (write_overflow_o)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ {1'b0, b[3:1]};
    endfunction

    function automatic exp_t obs();
        exp_t o;
        o.en   = write_enable_o;
        o.ptr  = write_pointer_o;
        o.addr = write_address_o;
        o.lvl  = write_level_o;
        o.full = write_full_o;
        o.af   = write_almost_full_o;
        o.ovf  = write_overflow_o;
        return o;
    endfunction

    // Drive one cycle of inputs and push the outputs expected after the edge.
    task automatic drive(input logic rst_v, input logic inc_v, input logic clr_v,
                         input logic [3:0] rptr_v);
        exp_t       e;
        logic [3:0] lvl;
        rst  = rst_v;
        inc  = inc_v;
        clr  = clr_v;
        rptr = rptr_v;
        if (rst_v) begin
            m_bin  = 4'd0;
            m_full = 1'b0;
            m_ovf  = 1'b0;
            e.lvl  = 4'd0;
            e.af   = 1'b0;
        end else begin
            m_ovf = (inc_v && m_full) ? 1'b1 : (clr_v ? 1'b0 : m_ovf);
            if (inc_v && !m_full) m_bin = m_bin + 4'd1;
            lvl    = m_bin - g2b(rptr_v);
            m_full = (lvl == 4'd8);
            e.lvl  = lvl;
            e.af   = (lvl >= thr);
        end
        e.ptr  = b2g(m_bin);
        e.addr = m_bin[2:0];
        e.full = m_full;
        e.ovf  = m_ovf;
        e.en   = inc_v & ~m_full;
        q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e, a;
        thr = 4'd0;
        for (int i = 0; i < 3; i++) begin
            drive((i < 2) ? 1'b1 : 1'b0, 1'b0, 1'b0, 4'd0);
            @(posedge clk); #1;
            e = q.pop_front(); a = obs(); n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL reset[%0d]: got %b want %b", i, a, e);
            end
            @(negedge clk);
        end
        // Threshold 0 raises almost-full on the first edge after reset.
        n_vec++;
        if (write_almost_full_o !== 1'b1 || write_pointer_o !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_thr0: got af=%b ptr=%b want af=1 ptr=0000",
                     write_almost_full_o, write_pointer_o);
        end
    endtask

    task automatic test_fill();
        exp_t e, a;
        thr = 4'd15;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'd0);
            @(posedge clk); #1;
            e = q.pop_front(); a = obs(); n_vec++;
            if (a !== e || write_pointer_o !== gtab[i] || write_level_o !== 4'(i + 1)) begin
                n_err++;
                $display("FAIL fill[%0d]: got %b want %b (gray %b)", i, a, e, gtab[i]);
            end
            @(negedge clk);
        end
        n_vec++;
        if (write_full_o !== 1'b1) begin
            n_err++;
            $display("FAIL fill_full: got %b want 1", write_full_o);
        end
    endtask

    task automatic test_overflow();
        exp_t e, a;
        logic inc_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic clr_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic ovf_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, inc_t[i], clr_t[i], 4'd0);
            @(posedge clk); #1;
            e = q.pop_front(); a = obs(); n_vec++;
            if (a !== e || write_pointer_o !== 4'b1100 || write_overflow_o !== ovf_t[i]
                || write_enable_o !== 1'b0) begin
                n_err++;
                $display("FAIL overflow[%0d]: got %b want %b", i, a, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_almost_full();
        exp_t e, a;
        thr = 4'd6;
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      drive(1'b1, 1'b0, 1'b0, 4'd0);
            else if (i < 7)  drive(1'b0, 1'b1, 1'b0, 4'd0);
            else             drive(1'b0, 1'b0, 1'b0, 4'b0001);
            @(posedge clk); #1;
            e = q.pop_front(); a = obs(); n_vec++;
            if (a !== e || write_almost_full_o !== (i == 6)) begin
                n_err++;
                $display("FAIL almost_full[%0d]: got %b want %b", i, a, e);
            end
            @(negedge clk);
        end
        n_vec++;
        if (write_level_o !== 4'd5) begin
            n_err++;
            $display("FAIL af_level: got %0d want 5", write_level_o);
        end
    endtask

    task automatic test_wrap();
        exp_t       e, a;
        logic [3:0] prev;
        thr = 4'd15;
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        @(posedge clk); #1; void'(q.pop_front()); @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'd0);
            @(posedge clk); #1; void'(q.pop_front()); @(negedge clk);
        end
        for (int i = 0; i < 20; i++) begin
            prev = write_pointer_o;
            drive(1'b0, 1'b1, 1'b0, b2g(m_bin - 4'd1));
            @(posedge clk); #1;
            e = q.pop_front(); a = obs(); n_vec++;
            if (a !== e || write_level_o !== 4'd2 || write_full_o !== 1'b0
                || $countones(prev ^ write_pointer_o) != 1) begin
                n_err++;
                $display("FAIL wrap[%0d]: got %b want %b prev %b", i, a, e, prev);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, a;
        thr = 4'd15;
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        @(posedge clk); #1; void'(q.pop_front()); @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'd0);
            @(posedge clk); #1; void'(q.pop_front()); @(negedge clk);
        end
        n_vec++;
        if (write_level_o !== 4'd5) begin
            n_err++;
            $display("FAIL mid_pre: got %0d want 5", write_level_o);
        end
        for (int i = 0; i < 2; i++) begin
            drive((i == 0) ? 1'b1 : 1'b0, 1'b1, 1'b1, 4'd0);
            @(posedge clk); #1;
            e = q.pop_front(); a = obs(); n_vec++;
            if (a !== e || write_level_o !== 4'(i)) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: got %b want %b", i, a, e);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst  = 1'b1;
        inc  = 1'b0;
        clr  = 1'b0;
        rptr = 4'd0;
        thr  = 4'd0;
        m_bin  = 4'd0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_almost_full();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
